// File: rtl/scan_mux_pkg.sv
// scan_mux_pkg: default sizing, mode encodings and select-width helper for scan_mux.
package scan_mux_pkg;
    localparam int W_DEF = 4;
    localparam int N_DEF = 4;
    localparam int DWELL_DEF = 2;
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN = 1'b1;
    function automatic int sel_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/scan_ctr.sv
// scan_ctr: scan channel index plus dwell counter; clear beats hold beats advance.
module scan_ctr
    import scan_mux_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int DWELL = DWELL_DEF,
    parameter int SELW = sel_w(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            hold,
    input  logic            advance,
    output logic [SELW-1:0] idx,
    output logic            last
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DWELL - 1);
    localparam logic [SELW-1:0] IMAX = SELW'(N - 1);
    logic [CW-1:0] r_cnt;
    logic [SELW-1:0] r_idx;
    assign last = r_cnt == CMAX;
    assign idx = r_idx;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (clear) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (!hold && advance) begin
            r_cnt <= last ? '0 : r_cnt + 1'b1;
            if (last) r_idx <= (r_idx == IMAX) ? '0 : r_idx + 1'b1;
        end
    end
endmodule

// File: rtl/scan_mux.sv
// scan_mux: registered N-channel selector with manual select or timed auto-scan.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N = N_DEF,
    parameter int DWELL = DWELL_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enb,
    input  logic                   mode,
    input  logic                   hold,
    input  logic [sel_w(N)-1:0]    sel,
    input  logic [N*W-1:0]         din,
    output logic [W-1:0]           mout,
    output logic [sel_w(N)-1:0]    mch,
    output logic                   mval,
    output logic                   swrap
);
    localparam int SELW = sel_w(N);
    localparam logic [SELW:0] NCH = (SELW + 1)'(N);
    localparam logic [SELW-1:0] IMAX = SELW'(N - 1);
    logic [SELW-1:0] w_idx, w_pick;
    logic w_last, w_ok, w_scan;
    logic [W-1:0] w_data;
    logic [W-1:0] r_mout;
    logic [SELW-1:0] r_mch;
    logic r_mval, r_swrap;
    assign w_scan = mode == MODE_SCAN;
    // Manual mode pins the scan state at zero unless hold freezes it first.
    scan_ctr #(.N(N), .DWELL(DWELL), .SELW(SELW)) u_ctr (
        .clk     (clk),
        .rst     (rst),
        .clear   (enb | (!hold && !w_scan)),
        .hold    (hold),
        .advance (w_scan),
        .idx     (w_idx),
        .last    (w_last)
    );
    assign w_pick = w_scan ? w_idx : sel;
    assign w_ok = w_scan || ({1'b0, sel} < NCH);
    always_comb begin
        w_data = '0;
        for (int i = 0; i < N; i++)
            if (w_pick == SELW'(i)) w_data = din[i*W +: W];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst || enb) begin
            r_mout <= '0;
            r_mch <= '0;
            r_mval <= 1'b0;
            r_swrap <= 1'b0;
        end else if (!hold) begin
            r_mout <= w_ok ? w_data : '0;
            r_mch <= w_ok ? w_pick : '0;
            r_mval <= w_ok;
            r_swrap <= w_scan && w_last && (w_idx == IMAX);
        end
    end
    assign mout = r_mout;
    assign mch = r_mch;
    assign mval = r_mval;
    assign swrap = r_swrap;
endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: table vectors, corner sequences and random stimulus against a dwell-time model.
module tb_scan_mux;
    localparam int W = 4;
    localparam int N = 4;
    localparam int DWELL = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enb = 1'b0;
    logic mode = 1'b0;
    logic hold = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [15:0] din = 16'h8421;
    logic [3:0] mout, mout3;
    logic [1:0] mch, mch3;
    logic mval, swrap, mval3, swrap3;
    int checks = 0;
    int passes = 0;
    logic [3:0] m_mout;
    int m_mch;
    logic m_mval, m_swrap;
    int m_t;
    typedef struct {
        logic e, h, m;
        logic [1:0] s;
        logic [3:0] xo;
        logic [1:0] xc;
        logic xv, xs;
    } vec_t;
    vec_t tbl[28];

    always #5 clk = ~clk;

    scan_mux #(.W(W), .N(N), .DWELL(DWELL)) dut (
        .clk(clk), .rst(rst), .enb(enb), .mode(mode), .hold(hold), .sel(sel),
        .din(din), .mout(mout), .mch(mch), .mval(mval), .swrap(swrap)
    );
    scan_mux #(.W(W), .N(3), .DWELL(DWELL)) dut3 (
        .clk(clk), .rst(rst), .enb(enb), .mode(mode), .hold(hold), .sel(sel),
        .din(din[11:0]), .mout(mout3), .mch(mch3), .mval(mval3), .swrap(swrap3)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_mout = '0; m_mch = 0; m_mval = 1'b0; m_swrap = 1'b0; m_t = 0;
    endtask

    // m_t counts un-held scan cycles since the scan restarted at channel 0.
    task automatic model_edge(input logic e, h, m, input logic [1:0] s, input logic [15:0] d);
        int k;
        if (e) model_reset();
        else if (!h) begin
            if (m) begin
                k = (m_t / DWELL) % N;
                m_mout = d[k*W +: W];
                m_mch = k;
                m_mval = 1'b1;
                m_swrap = (k == N - 1) && (m_t % DWELL == DWELL - 1);
                m_t = (m_t + 1) % (N * DWELL);
            end else begin
                m_t = 0;
                m_swrap = 1'b0;
                m_mval = int'(s) < N;
                m_mch = m_mval ? int'(s) : 0;
                m_mout = m_mval ? d[int'(s)*W +: W] : '0;
            end
        end
    endtask

    task automatic step(input logic e, h, m, input logic [1:0] s);
        enb = e; hold = h; mode = m; sel = s;
        @(posedge clk);
        model_edge(e, h, m, s, din);
        #1;
        chk("model_mout", int'(mout), int'(m_mout));
        chk("model_mch", int'(mch), m_mch);
        chk("model_mval", int'(mval), int'(m_mval));
        chk("model_swrap", int'(swrap), int'(m_swrap));
    endtask

    task automatic async_reset_check(input string nm);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk({nm, "_mout"}, int'(mout), 0);
        chk({nm, "_mch"}, int'(mch), 0);
        chk({nm, "_mval"}, int'(mval), 0);
        chk({nm, "_swrap"}, int'(swrap), 0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{0, 0, 0, 2'd0, 4'h1, 2'd0, 1, 0};
        tbl[1]  = '{0, 0, 0, 2'd1, 4'h2, 2'd1, 1, 0};
        tbl[2]  = '{0, 0, 0, 2'd3, 4'h8, 2'd3, 1, 0};
        tbl[3]  = '{0, 1, 0, 2'd0, 4'h8, 2'd3, 1, 0};
        tbl[4]  = '{0, 0, 1, 2'd0, 4'h1, 2'd0, 1, 0};
        tbl[5]  = '{0, 0, 1, 2'd0, 4'h1, 2'd0, 1, 0};
        tbl[6]  = '{0, 0, 1, 2'd0, 4'h2, 2'd1, 1, 0};
        tbl[7]  = '{0, 0, 1, 2'd0, 4'h2, 2'd1, 1, 0};
        tbl[8]  = '{0, 0, 1, 2'd0, 4'h4, 2'd2, 1, 0};
        tbl[9]  = '{0, 0, 1, 2'd0, 4'h4, 2'd2, 1, 0};
        tbl[10] = '{0, 0, 1, 2'd0, 4'h8, 2'd3, 1, 0};
        tbl[11] = '{0, 0, 1, 2'd0, 4'h8, 2'd3, 1, 1};
        tbl[12] = '{0, 0, 1, 2'd0, 4'h1, 2'd0, 1, 0};
        tbl[13] = '{0, 0, 0, 2'd2, 4'h4, 2'd2, 1, 0};
        tbl[14] = '{0, 0, 1, 2'd0, 4'h1, 2'd0, 1, 0};
        tbl[15] = '{0, 0, 1, 2'd0, 4'h1, 2'd0, 1, 0};
        tbl[16] = '{0, 0, 1, 2'd0, 4'h2, 2'd1, 1, 0};
        tbl[17] = '{0, 1, 1, 2'd0, 4'h2, 2'd1, 1, 0};
        tbl[18] = '{0, 1, 1, 2'd0, 4'h2, 2'd1, 1, 0};
        tbl[19] = '{0, 1, 1, 2'd0, 4'h2, 2'd1, 1, 0};
        tbl[20] = '{0, 0, 1, 2'd0, 4'h2, 2'd1, 1, 0};
        tbl[21] = '{0, 0, 1, 2'd0, 4'h4, 2'd2, 1, 0};
        tbl[22] = '{1, 0, 1, 2'd0, 4'h0, 2'd0, 0, 0};
        tbl[23] = '{0, 0, 1, 2'd0, 4'h1, 2'd0, 1, 0};
        tbl[24] = '{0, 0, 1, 2'd0, 4'h1, 2'd0, 1, 0};
        tbl[25] = '{0, 0, 1, 2'd0, 4'h2, 2'd1, 1, 0};
        tbl[26] = '{1, 1, 1, 2'd0, 4'h0, 2'd0, 0, 0};
        tbl[27] = '{0, 0, 0, 2'd3, 4'h8, 2'd3, 1, 0};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mout", int'(mout), 0);
        chk("rst_mval", int'(mval), 0);
        chk("rst_swrap", int'(swrap), 0);
        rst = 1'b0;

        for (int i = 0; i < 28; i++) begin
            step(tbl[i].e, tbl[i].h, tbl[i].m, tbl[i].s);
            chk($sformatf("tbl%0d_mout", i), int'(mout), int'(tbl[i].xo));
            chk($sformatf("tbl%0d_mch", i), int'(mch), int'(tbl[i].xc));
            chk($sformatf("tbl%0d_mval", i), int'(mval), int'(tbl[i].xv));
            chk($sformatf("tbl%0d_swrap", i), int'(swrap), int'(tbl[i].xs));
        end

        step(0, 0, 1, 2'd0);
        step(0, 0, 1, 2'd0);
        step(0, 0, 1, 2'd0);
        async_reset_check("midscan_rst");
        step(1, 0, 1, 2'd0);
        chk("post_rst_enb_mout", int'(mout), 0);
        chk("post_rst_enb_mval", int'(mval), 0);
        step(0, 0, 1, 2'd0);
        chk("post_rst_scan_mout", int'(mout), 1);

        step(0, 0, 0, 2'd3);
        chk("n3_oob_mout", int'(mout3), 0);
        chk("n3_oob_mval", int'(mval3), 0);
        chk("n3_oob_mch", int'(mch3), 0);
        step(0, 0, 0, 2'd2);
        chk("n3_ch2_mout", int'(mout3), 4);
        chk("n3_ch2_mval", int'(mval3), 1);
        chk("n3_ch2_mch", int'(mch3), 2);

        for (int i = 0; i < 600; i++) begin
            din = 16'($urandom);
            step($urandom_range(0, 15) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 99) == 0) async_reset_check("rand_rst");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 The block SHALL have parameter W, default 4: data width per channel, W >= 1.
REQ-002 The block SHALL have parameter N, default 4: channel count, N >= 2.
REQ-003 The block SHALL have parameter DWELL, default 2: scan-mode cycles per channel, DWELL >= 1.
REQ-004 The block SHALL have derived constant SELW = max(1, ceil(log2(N))).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port enb, input, 1 bit: blanking; when high, outputs are forced to zero.
REQ-008 The block SHALL have port mode, input, 1 bit: 0 = manual select, 1 = auto-scan.
REQ-009 The block SHALL have port hold, input, 1 bit: freezes the output registers and scan state.
REQ-010 The block SHALL have port sel, input, SELW bits: channel index used in manual mode.
REQ-011 The block SHALL have port din, input, N*W bits: channel i occupies bits i*W through i*W+W-1.
REQ-012 The block SHALL have port mout, output, W bits: registered selected data.
REQ-013 The block SHALL have port mch, output, SELW bits: channel index of the data currently on mout.
REQ-014 The block SHALL have port mval, output, 1 bit: mout holds valid channel data.
REQ-015 The block SHALL have port swrap, output, 1 bit: one-cycle pulse marking the last scan cycle of channel N-1.

Function
REQ-016 All outputs SHALL be registered, with a latency of 1 clock from inputs to outputs.
REQ-017 Priority SHALL be: rst > enb > hold > mode.
REQ-018 With enb=1, each edge SHALL load mout=0, mch=0, mval=0, swrap=0, scan index 0 and dwell count 0.
REQ-019 With enb=0 and hold=1, all output registers, the scan index and the dwell count SHALL keep their values.
REQ-020 With mode=0 and sel < N, each edge SHALL load mout = channel sel, mch = sel, mval=1, swrap=0.
REQ-021 With mode=0 and sel >= N, each edge SHALL load mout=0, mch=0, mval=0, swrap=0.
REQ-022 While mode=0, the scan index and dwell count SHALL be held at 0, so that scan always starts at channel 0.
REQ-023 With mode=1, each edge SHALL load mout = channel idx, mch = idx, mval=1, where idx is the current scan index.
REQ-024 In mode=1, the dwell count SHALL increment on each edge; when it equals DWELL-1, it SHALL clear to 0 and idx SHALL advance, wrapping from N-1 to 0.
REQ-025 Each channel SHALL therefore appear on mout for exactly DWELL consecutive un-held cycles.
REQ-026 swrap SHALL be registered high together with the output of idx=N-1 when the dwell count equals DWELL-1; otherwise it SHALL be 0.
REQ-027 On a switch from mode 1 to 0 mid-scan, the scan state SHALL be discarded, and the next edge SHALL follow REQ-020/021.
REQ-028 din changes SHALL be captured on the next edge with no other side effect.

Reset
REQ-029 While rst=1, immediately and without a clock edge: mout=0, mch=0, mval=0, swrap=0, scan index 0, dwell count 0.
REQ-030 On release of rst, the first edge SHALL follow REQ-017 to REQ-027; an assertion mid-scan SHALL abort the scan, with no partial dwell retained.

Structure
REQ-031 Package scan_mux_pkg SHALL hold the default W, N and DWELL values and the mode constants MODE_MANUAL=0 and MODE_SCAN=1.
REQ-032 Sub-module scan_ctr SHALL contain the scan index and dwell counter, with clear, hold and advance inputs and idx and last outputs.
REQ-033 scan_mux SHALL contain the channel-select logic and the output registers; it SHALL contain no latches and no combinational path from input to output.

Verification (W=4, N=4, DWELL=2, din channels 0..3 = 0001, 0010, 0100, 1000 unless stated)
REQ-034 Assert rst between edges after activity -> mout=0000, mval=0, mch=0 immediately; release, then enb=1 -> outputs stay 0000/0.
REQ-035 enb=0, mode=0, sel=0 then sel=1 -> mout=0001/mch=0, then 0010/mch=1, mval=1, each one edge after the sel change.
REQ-036 N=3 build, mode=0, sel=3 -> mout=0000, mval=0; then sel=2 -> mout = channel 2, mval=1.
REQ-037 mode=1 from idle -> mout sequence 0001, 0001, 0010, 0010, 0100, 0100, 1000, 1000, 0001; swrap high only with the second 1000.
REQ-038 mode=1, hold=1 for 3 cycles after the first 0010 -> mout stays 0010; after release, a second 0010 appears, then 0100, with no channel skipped.
REQ-039 mode=1 at the first 0100, pulse enb for 1 cycle -> mout=0000/mval=0 for one cycle; the scan then restarts at 0001 for 2 cycles.
